// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with framing-error, break and command-character detection.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CMD_CHAR   = 'h41
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx_in,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 cmd_match
);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [31:0]   CMD_WORD  = 32'(CMD_CHAR);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_line;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_buf;
  logic                 par_bit;
  logic                 par_flag;

  // Resets to the idle (high) level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};
  end

  assign rx_line = sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_buf     <= '0;
      par_bit       <= 1'b0;
      par_flag      <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      framing_err   <= 1'b0;
      parity_err    <= 1'b0;
      break_det     <= 1'b0;
      cmd_match     <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      framing_err   <= 1'b0;
      parity_err    <= 1'b0;
      break_det     <= 1'b0;
      cmd_match     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_line) begin
            state    <= S_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            par_flag <= 1'b0;
          end
        end

        S_START: begin
          if (os_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              state    <= rx_line ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_buf <= {rx_line, shift_buf[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= PARITY_EN ? S_PARITY : S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_line;
              par_flag <= (^shift_buf) ^ rx_line ^ parity_odd;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              rx_data  <= shift_buf;
              if (rx_line) begin
                rx_data_valid <= 1'b1;
                parity_err    <= PARITY_EN & par_flag;
                cmd_match     <= (32'(shift_buf) == CMD_WORD);
                state         <= S_IDLE;
              end else begin
                // An all-zero frame with a low stop bit is a held-low line, not a bad frame.
                if (shift_buf == '0 && !par_bit) break_det   <= 1'b1;
                else                             framing_err <= 1'b1;
                state <= S_BREAK_WAIT;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_BREAK_WAIT: begin
          if (!rx_line) begin
            tick_cnt <= '0;
          end else if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized frames
// compared against a frame-level reference model of the receiver's outcomes.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int          DATA_BITS  = 8;
  localparam int          OVERSAMPLE = 16;
  localparam int unsigned CMD_CHAR   = 'h41;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 os_tick = 1'b0;
  logic                 rx_in = 1'b1;
  logic                 parity_odd = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 framing_err;
  logic                 parity_err;
  logic                 break_det;
  logic                 cmd_match;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       brk;
    logic       cmd;
    logic [7:0] data;
  } evt_t;

  evt_t seen[$];
  evt_t none;

  uart_rx_os #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .CMD_CHAR  (CMD_CHAR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .os_tick      (os_tick),
    .rx_in        (rx_in),
    .parity_odd   (parity_odd),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .framing_err  (framing_err),
    .parity_err   (parity_err),
    .break_det    (break_det),
    .cmd_match    (cmd_match)
  );

  always #5 clk = ~clk;

  // One os_tick every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  // Every clock with any pulse high is one observed event, so a 2-clk pulse shows as two.
  always @(negedge clk) begin
    if (rx_data_valid || framing_err || parity_err || break_det || cmd_match)
      seen.push_back('{valid: rx_data_valid, ferr: framing_err, perr: parity_err,
                       brk: break_det, cmd: cmd_match, data: rx_data});
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outcome of one frame as the receiver is required to report it.
  function automatic evt_t model(input logic [7:0] d, input logic p, input logic stop,
                                 input logic odd);
    evt_t e;
    e.data  = d;
    e.valid = stop;
    e.cmd   = stop && (32'(d) == CMD_CHAR);
    e.perr  = stop && PARITY_EN && ((^d) ^ p ^ odd);
    e.brk   = !stop && (d == 8'h00) && !(PARITY_EN && p);
    e.ferr  = !stop && !e.brk;
    return e;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ parity_odd;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_in = b;
    wait_ticks(OVERSAMPLE);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    if (PARITY_EN) send_bit(p);
    send_bit(stop);
  endtask

  task automatic check_events(input string tag, input int n_exp, input evt_t e);
    evt_t got;
    check({tag, " pulses"}, 32'(seen.size()), 32'(n_exp));
    if (n_exp == 1 && seen.size() != 0) begin
      got = seen.pop_front();
      check({tag, " flags"}, 32'({got.valid, got.ferr, got.perr, got.brk, got.cmd}),
                             32'({e.valid, e.ferr, e.perr, e.brk, e.cmd}));
      check({tag, " data"}, 32'(got.data), 32'(e.data));
      check({tag, " rx_data"}, 32'(rx_data), 32'(e.data));
    end
    seen.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                           input logic stop);
    send_frame(d, p, stop);
    check_events(tag, 1, model(d, p, stop, parity_odd));
  endtask

  initial begin
    none = '{valid: 1'b0, ferr: 1'b0, perr: 1'b0, brk: 1'b0, cmd: 1'b0, data: 8'h00};

    repeat (5) @(negedge clk);
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset pulses", 32'({rx_data_valid, framing_err, parity_err, break_det, cmd_match}),
          32'h0);
    rst_n = 1'b1;
    wait_ticks(1);
    idle(4);

    run_frame("cmd 0x41", 8'h41, good_par(8'h41), 1'b1);

    // Low for 4 ticks then high: START rejects it at its mid-bit sample.
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(4);
    idle(6);
    check_events("glitch", 0, none);
    run_frame("after glitch 0x3C", 8'h3C, good_par(8'h3C), 1'b1);

    run_frame("framing 0x55", 8'h55, good_par(8'h55), 1'b0);
    idle(OVERSAMPLE);
    run_frame("after framing 0x3C", 8'h3C, good_par(8'h3C), 1'b1);

    // Held low for 12 bit times: one break, then the line must recover for a full bit.
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(12 * OVERSAMPLE);
    check_events("break", 1, model(8'h00, 1'b0, 1'b0, parity_odd));
    idle(8);
    send_frame(8'h00, 1'b0, 1'b1);
    check_events("short recovery", 0, none);
    run_frame("after break 0x3C", 8'h3C, good_par(8'h3C), 1'b1);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    run_frame("parity bad 0x41", 8'h41, 1'b1, 1'b1);
    run_frame("parity good 0x41", 8'h41, 1'b0, 1'b1);
`endif

    // Reset in the middle of data bit 3 of 0xA5.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(8'hA5 >> i));
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(OVERSAMPLE / 2);
    @(negedge clk);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("mid-frame reset rx_data", 32'(rx_data), 32'h0);
    rst_n = 1'b1;
    wait_ticks(1);
    idle(20);
    check_events("aborted 0xA5", 0, none);
    check("after abort rx_data", 32'(rx_data), 32'h0);
    run_frame("after reset 0x5A", 8'h5A, good_par(8'h5A), 1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       p;
      logic       stop;
      d          = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'(CMD_CHAR);
      if ($urandom_range(0, 9) == 0) d = 8'h00;
      p          = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 4) != 0);
      parity_odd = 1'($urandom_range(0, 1));
      run_frame($sformatf("random %0d", n), d, p, stop);
      if (stop) idle($urandom_range(0, 3));
      else      idle(OVERSAMPLE);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; the legal range is 5..9.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning os_tick pulses per bit period; it must be even and at least 4.
REQ-003 The block SHALL have parameter CMD_CHAR, default 8'h41, meaning the character that raises cmd_match; it is compared against rx_data[DATA_BITS-1:0] zero-extended.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port os_tick, input, 1 bit: oversample enable, a single-clk pulse.
REQ-007 The block SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS bits: last received word.
REQ-010 The block SHALL have port rx_data_valid, output, 1 bit: one-clk pulse marking a good-stop frame.
REQ-011 The block SHALL have ports framing_err, parity_err, break_det and cmd_match, each output, 1 bit, each a one-clk pulse.

Function
REQ-012 The block SHALL pass rx_in through a 2-flop synchroniser that resets to 1; all logic SHALL use only the synchronised value.
REQ-013 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT; any illegal encoding SHALL return to IDLE.
REQ-014 In IDLE, a synchronised low SHALL move to START, clearing the tick counter and the bit counter.
REQ-015 In START, after OVERSAMPLE/2 ticks (mid-bit), a low line SHALL move to DATA with the tick counter cleared; a high line is a glitch and SHALL return to IDLE with no outputs.
REQ-016 In DATA, the line SHALL be sampled every OVERSAMPLE ticks, LSB first, into a shift buffer; after DATA_BITS samples the machine SHALL go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-017 In PARITY, the line SHALL be sampled after OVERSAMPLE ticks; the parity mismatch flag is computed as XOR of the data bits, the parity bit and parity_odd.
REQ-018 In STOP, the line SHALL be sampled after OVERSAMPLE ticks; rx_data SHALL load the buffer on every completed frame, and the outputs SHALL be registered so they appear on the clk after the stop-sample tick.
REQ-019 A high stop bit SHALL pulse rx_data_valid; in the same clk, parity_err SHALL pulse if there was a mismatch and cmd_match SHALL pulse if the data equals CMD_CHAR; the machine then returns to IDLE.
REQ-020 A low stop bit with nonzero data or parity bit SHALL pulse framing_err only and go to BREAK_WAIT.
REQ-021 A low stop bit with all data and parity bits zero SHALL pulse break_det only and go to BREAK_WAIT.
REQ-022 BREAK_WAIT SHALL stay until the synchronised line has been high for one full bit period (OVERSAMPLE ticks), then go to IDLE.
REQ-023 States other than IDLE and BREAK_WAIT SHALL advance only on os_tick; os_tick low SHALL freeze the counters.
REQ-024 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and wrap to 0 at OVERSAMPLE-1; the bit counter SHALL be $clog2(DATA_BITS+1) bits wide.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, clear both counters and the buffer, set rx_data to 0, set all pulse outputs to 0 and set the synchroniser to 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no pulse output SHALL be asserted for it after reset is released.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, the frame SHALL be start, DATA_BITS data bits, one parity bit, then stop, and parity_err SHALL be live.
REQ-028 Without UART_RX_PARITY_EN, the frame SHALL have no parity bit, PARITY SHALL be unreachable, parity_err SHALL be tied to 0 and parity_odd SHALL be ignored; the port list SHALL be unchanged.

Verification
REQ-029 With defaults and no parity, sending 0x41 with a good stop SHALL give rx_data=0x41, rx_data_valid and cmd_match each high for exactly 1 clk, and all error pulses low.
REQ-030 A line glitch low for 4 os_ticks and then high SHALL produce no output pulse, and the state SHALL be IDLE by tick 8.
REQ-031 Sending 0x55 with a low stop bit SHALL pulse framing_err, give rx_data=0x55 and leave rx_data_valid low; a following 0x3C sent after 16 high ticks SHALL be received correctly.
REQ-032 Holding the line low for 12 bit times SHALL pulse break_det once, and no frame SHALL be accepted until the line has been high for 16 ticks.
REQ-033 With UART_RX_PARITY_EN and parity_odd=0, 0x41 with parity bit 1 SHALL pulse rx_data_valid and parity_err together; with parity bit 0, parity_err SHALL stay low.
REQ-034 Asserting rst_n low at data bit 3 of 0xA5 SHALL leave rx_data=0x00 with no pulses, and a following 0x5A SHALL be received correctly.
